// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned SUB_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sub_state_t;

    // Bit counter width; never below one bit so the counter always exists
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// SERIAL_SUB_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEF
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a, b,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, bout
    );
`endif

endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    // Difference bit and borrow of a single bit position
    always_comb begin
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor (diff = a - b), LSB first, one bit
// per clock, behind a start/done handshake.
// Optional feature macro: SERIAL_SUB_OVF_EN (adds registered signed overflow ovf).
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Reject unsupported widths at elaboration
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("serial_subtractor: WIDTH must be in 2..32");
        end
    endgenerate

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] opa_q,   opa_d;
    logic [WIDTH-1:0] opb_q,   opb_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             br_q,    br_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] diff_q,  diff_d;
    logic             bout_q,  bout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept because the operand shifters lose them
    logic             sa_q,    sa_d;
    logic             sb_q,    sb_d;
    logic             ovf_q,   ovf_d;
`endif

    logic bit_d;
    logic bit_bo;

    full_subtractor u_full_subtractor (
        .a    (opa_q[0]),
        .b    (opb_q[0]),
        .bin  (br_q),
        .d    (bit_d),
        .bout (bit_bo)
    );

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        shreg_d = shreg_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    opa_d   = bus.a;
                    opb_d   = bus.b;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    shreg_d = '0;
`ifdef SERIAL_SUB_OVF_EN
                    sa_d    = bus.a[WIDTH-1];
                    sb_d    = bus.b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                shreg_d = {bit_d, shreg_q[WIDTH-1:1]};
                opa_d   = {1'b0, opa_q[WIDTH-1:1]};
                opb_d   = {1'b0, opb_q[WIDTH-1:1]};
                br_d    = bit_bo;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish the completed result in one step
                    state_d = DONE;
                    diff_d  = {bit_d, shreg_q[WIDTH-1:1]};
                    bout_d  = bit_bo;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d   = (sa_q != sb_q) && (bit_d != sa_q);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            shreg_q <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            shreg_q <= shreg_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_SUB_OVF_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8).
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_bout;
        logic       exp_ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One operation; called just after a rising edge with the DUT in IDLE
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] ed, input logic eb, input logic eo);
        logic [7:0] prev;
        int         n;
        logic       held;
        prev      = bus.diff;
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = ~a;
        bus.b     = ~b;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        n    = 0;
        held = 1'b1;
        while (!bus.done && n < int'(W) + 4) begin
            if (bus.diff !== prev) held = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check("done_latency", 32'(n), 32'(W));
        check("diff_held_during_run", 32'(held), 32'd1);
        check("busy_in_done", 32'(bus.busy), 32'd1);
        check("diff", 32'(bus.diff), 32'(ed));
        check("bout", 32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(bus.ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected X in vector table");
`endif
        @(posedge clk); #1;
        check("done_busy_after_done", 32'({bus.done, bus.busy}), 32'd0);
        check("diff_holds_in_idle", 32'(bus.diff), 32'(ed));
    endtask

    vec_t vecs[9];

    initial begin
        int dones;
        int done_at;
        logic [7:0] done_diff;
        logic       done_bout;

        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
        vecs[7] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};
        vecs[8] = '{8'h10, 8'h10, 8'h00, 1'b0, 1'b0};

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_diff", 32'(bus.diff), 32'd0);
        check("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table vectors, issued back-to-back
        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_bout, vecs[i].exp_ovf);
        end

        // Second start three cycles into RUN must be ignored
        bus.start = 1'b1;
        bus.a     = 8'h20;
        bus.b     = 8'h05;
        @(posedge clk); #1;
        bus.start = 1'b0;
        dones     = 0;
        done_at   = -1;
        done_diff = '0;
        done_bout = 1'b0;
        for (int c = 1; c <= int'(W) + 6; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                bus.start = 1'b1;
                bus.a     = 8'h01;
                bus.b     = 8'h02;
            end
            if (c == 3) bus.start = 1'b0;
            if (bus.done) begin
                dones++;
                if (done_at < 0) begin
                    done_at   = c;
                    done_diff = bus.diff;
                    done_bout = bus.bout;
                end
            end
        end
        check("ignored_start_done_count", 32'(dones), 32'd1);
        check("ignored_start_latency", 32'(done_at), 32'(W));
        check("ignored_start_diff", 32'(done_diff), 32'h1B);
        check("ignored_start_bout", 32'(done_bout), 32'd0);
        check("ignored_start_idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of RUN discards the operation
        bus.start = 1'b1;
        bus.a     = 8'h44;
        bus.b     = 8'h11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_before_midrun_reset", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrun_rst_busy", 32'(bus.busy), 32'd0);
        check("midrun_rst_done", 32'(bus.done), 32'd0);
        check("midrun_rst_diff", 32'(bus.diff), 32'd0);
        check("midrun_rst_bout", 32'(bus.bout), 32'd0);
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("midrun_rst_no_done", 32'(dones), 32'd0);
        run_op(8'h44, 8'h11, 8'h33, 1'b0, 1'b0);

        // Reset wins over start at the same edge
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        @(posedge clk); #1;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        check("rst_priority_busy", 32'(bus.busy), 32'd0);
        dones = 0;
        for (int c = 0; c < int'(W) + 4; c++) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        check("rst_priority_no_done", 32'(dones), 32'd0);
        check("rst_priority_diff", 32'(bus.diff), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop if the run never reaches its summary
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "watchdog expired");
    end

endmodule
